rom_load_ctrl: RTL and testbench
================================

ROM_LOAD_CTRL -- requirements
Module: rom_load_ctrl

Interface
REQ-001 SHALL have parameter ROM_INDEX, default 8'd0, the ioctl_index value selecting game ROM.
REQ-002 SHALL have parameter ADDR_W, default 14, the target ROM address width (16 KiB).
REQ-003 SHALL have parameter HOLD_CYCLES, default 16, the post-load reset hold length in clk_sys cycles (range 1..255).
REQ-004 SHALL have port: clk_sys  in  1  sole clock.
REQ-005 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: ioctl_download in 1, ioctl_index in 8, ioctl_wr in 1, ioctl_addr in 25, ioctl_dout in 8 (HPS download bus).
REQ-007 SHALL have port: ioctl_wait  out  1  back-pressure to HPS.
REQ-008 SHALL have ports: dn_addr out ADDR_W, dn_data out 8, dn_wr out 1 (write port to the game ROM).
REQ-009 SHALL have port: dn_ready  in  1  target accepts a write in any cycle where dn_wr and dn_ready are both 1.
REQ-010 SHALL have ports: core_reset out 1 (game core reset), loaded out 1, byte_count out ADDR_W+1, overflow out 1.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, DRAIN, HOLD, RUN.
REQ-012 A download is active only when ioctl_download=1 and ioctl_index==ROM_INDEX; other indexes are ignored in every state.
REQ-013 IDLE/RUN/HOLD -> LOAD on rising edge of an active download; entry clears byte_count, overflow, loaded, and the hold counter.
REQ-014 LOAD -> DRAIN when the active download falls; DRAIN -> HOLD when the FIFO is empty and no write is pending.
REQ-015 HOLD counts HOLD_CYCLES cycles, then -> RUN if byte_count!=0, else -> IDLE.
REQ-016 core_reset SHALL be 1 in IDLE, LOAD, DRAIN, HOLD and 0 only in RUN; loaded SHALL be 1 only in RUN.
REQ-017 Writes are buffered in a 2-entry FIFO of {addr, data}; push when ioctl_wr=1 in LOAD and ioctl_addr < 2**ADDR_W and (count<2 or pop this cycle).
REQ-018 ioctl_wr with ioctl_addr >= 2**ADDR_W SHALL be discarded and set overflow (sticky until next LOAD entry).
REQ-019 ioctl_wr while FIFO full with no simultaneous pop SHALL be discarded and set overflow.
REQ-020 ioctl_wait SHALL equal (count==2), combinational from registered count.
REQ-021 dn_wr SHALL equal (count!=0) in LOAD or DRAIN, else 0; dn_addr/dn_data SHALL present the FIFO head; head pops when dn_wr and dn_ready.
REQ-022 Latency: byte pushed in cycle N appears on dn_wr in cycle N+1 when the FIFO was empty; order preserved.
REQ-023 byte_count SHALL increment per accepted push and saturate at 2**ADDR_W.
REQ-024 Simultaneous push and pop SHALL leave count unchanged.
REQ-025 A new active download rising while in HOLD SHALL restart in LOAD, abandoning the hold count.

Reset
REQ-026 reset SHALL force IDLE, flush the FIFO (count=0), and drive core_reset=1, loaded=0, dn_wr=0, ioctl_wait=0, byte_count=0, overflow=0, dn_addr=0, dn_data=0.
REQ-027 reset asserted mid-LOAD SHALL drop all buffered bytes; a download still active after reset release is not re-entered until its next rising edge.

Structure
REQ-028 FSM state enum and the default ROM_INDEX constant SHALL live in the shared core package.
REQ-029 The 2-entry FIFO SHALL be one sub-module, dn_fifo2, with push/pop/count/full/empty ports.

Verification
REQ-030 Load 4 bytes addr 0..3 = A5,5A,01,FF with dn_ready=1 -> four dn_wr pulses, each one cycle after its ioctl_wr, matching data; after fall, 16-cycle hold, then core_reset=0, loaded=1, byte_count=4.
REQ-031 dn_ready=0 for 10 cycles during burst of 3 writes -> ioctl_wait=1 after second push; third write issued only after wait drops; no overflow; bytes delivered in order.
REQ-032 ioctl_wr at addr 0x4000 data 0x77 -> no dn_wr, overflow=1, byte_count unchanged.
REQ-033 Download with ioctl_index=1 -> FSM stays in current state, no dn_wr, core_reset unchanged.
REQ-034 Zero-byte download -> LOAD, DRAIN, HOLD 16 cycles, back to IDLE, loaded=0, core_reset=1.
REQ-035 reset pulse with 2 bytes buffered in LOAD -> next cycle IDLE, dn_wr=0, count=0, byte_count=0; from RUN, new index-0 download -> core_reset=1, loaded=0 in the next cycle.

Source files
------------

// File: rtl/rom_load_ctrl_pkg.sv
// Shared definitions for the ROM download controller: FSM states, default
// download index and the target-range check used on incoming ioctl addresses.
package rom_load_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RUN   = 3'd4
  } state_t;

  localparam logic [7:0] DEFAULT_ROM_INDEX = 8'd0;

  // True when a 25-bit ioctl address fits inside a 2**aw byte ROM.
  function automatic logic addr_in_range(input logic [24:0] addr, input int unsigned aw);
    return (addr >> aw) == 25'd0;
  endfunction

endpackage

// File: rtl/rom_load_ctrl_dn_fifo2.sv
// Two-entry FIFO decoupling the HPS download bus from the ROM write port.
// Pop on empty and push on full (without a same-cycle pop) are ignored.
module dn_fifo2 #(
  parameter int W = 22
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_pop;
  logic         do_push;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rom_load_ctrl.sv
// Game ROM download controller: filters the HPS ioctl stream by index, buffers
// writes toward the ROM, and sequences the game core reset around a load.
module rom_load_ctrl
  import rom_load_ctrl_pkg::*;
#(
  parameter logic [7:0] ROM_INDEX   = DEFAULT_ROM_INDEX,
  parameter int         ADDR_W      = 14,
  parameter int         HOLD_CYCLES = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              dn_wr,
  input  logic              dn_ready,
  output logic              core_reset,
  output logic              loaded,
  output logic [ADDR_W:0]   byte_count,
  output logic              overflow
);

  localparam int              FW        = ADDR_W + 8;
  localparam logic [ADDR_W:0] BC_MAX    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] BC_ONE    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [7:0]      HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t          state;
  state_t          state_next;
  logic            active;
  logic            active_q;
  logic            rise;
  logic [7:0]      hold_cnt;
  logic [1:0]      fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic [FW-1:0]   fifo_head;
  logic            wr_req;
  logic            in_range;
  logic            pop;
  logic            push;
  logic            drop;

  assign active   = ioctl_download && (ioctl_index == ROM_INDEX);
  assign rise     = active && !active_q;
  assign wr_req   = (state == ST_LOAD) && active && ioctl_wr;
  assign in_range = addr_in_range(ioctl_addr, ADDR_W);
  assign pop      = dn_wr && dn_ready;
  assign push     = wr_req && in_range && (!fifo_full || pop);
  assign drop     = wr_req && !push;

  assign ioctl_wait = (fifo_count == 2'd2);
  assign dn_wr      = ((state == ST_LOAD) || (state == ST_DRAIN)) && !fifo_empty;
  assign core_reset = (state != ST_RUN);
  assign loaded     = (state == ST_RUN);
  assign {dn_addr, dn_data} = fifo_head;

  dn_fifo2 #(
    .W(FW)
  ) u_fifo (
    .clk       (clk_sys),
    .reset     (reset),
    .push      (push),
    .push_data ({ioctl_addr[ADDR_W-1:0], ioctl_dout}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_RUN: begin
        if (rise) state_next = ST_LOAD;
        else      state_next = state;
      end
      ST_LOAD: begin
        if (!active) state_next = ST_DRAIN;
        else         state_next = ST_LOAD;
      end
      ST_DRAIN: begin
        if (fifo_empty) state_next = ST_HOLD;
        else            state_next = ST_DRAIN;
      end
      ST_HOLD: begin
        // A fresh download abandons the hold; an empty load falls back to IDLE.
        if (rise)                          state_next = ST_LOAD;
        else if (hold_cnt != HOLD_LAST)    state_next = ST_HOLD;
        else if (byte_count != '0)         state_next = ST_RUN;
        else                               state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Sampling the live download level during reset keeps a download that is
  // still high at release from being mistaken for a new rising edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_IDLE;
      active_q   <= active;
      hold_cnt   <= 8'd0;
      byte_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state    <= state_next;
      active_q <= active;
      hold_cnt <= ((state == ST_HOLD) && (state_next == ST_HOLD)) ? hold_cnt + 8'd1 : 8'd0;
      if ((state_next == ST_LOAD) && (state != ST_LOAD)) begin
        byte_count <= '0;
        overflow   <= 1'b0;
      end else begin
        if (push && (byte_count != BC_MAX)) begin
          byte_count <= byte_count + BC_ONE;
        end
        if (drop) begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Directed bench for rom_load_ctrl: accepted ROM writes are checked by a
// scoreboard monitor; status outputs are checked inline after each step.
`timescale 1ns/1ps
module tb_rom_load_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [13:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        dn_ready;
  logic        core_reset;
  logic        loaded;
  logic [14:0] byte_count;
  logic        overflow;

  typedef struct {
    logic [13:0] addr;
    logic [7:0]  data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  rom_load_ctrl dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .dn_ready       (dn_ready),
    .core_reset     (core_reset),
    .loaded         (loaded),
    .byte_count     (byte_count),
    .overflow       (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Pops one expectation for every write the ROM port accepts.
  task automatic monitor();
    forever begin
      @(negedge clk_sys);
      if (dn_wr && dn_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_dn_wr: got addr 0x%0h data 0x%0h expected no write", dn_addr, dn_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("dn_addr", 32'(dn_addr), 32'(e.addr));
          chk("dn_data", 32'(dn_data), 32'(e.data));
          if (e.cyc != 0) chk("dn_wr_latency", cyc, e.cyc);
        end
      end
    end
  endtask

  // One ioctl write, honouring ioctl_wait; in-range bytes are expected on the ROM port.
  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input bit lat);
    int   n;
    exp_t e;
    n = 0;
    while (ioctl_wait && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout: got ioctl_wait=1 for %0d cycles expected release", n);
    end
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (a < 25'h0004000) begin
      e.addr = a[13:0];
      e.data = d;
      e.cyc  = lat ? cyc + 1 : 0;
      sb.push_back(e);
    end
    step();
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_loaded(output int n);
    n = 0;
    while (!loaded && n < 100) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    logic [7:0] t1_data [4];
    t1_data = '{8'hA5, 8'h5A, 8'h01, 8'hFF};

    fork
      monitor();
      begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1, "watchdog expired");
      end
    join_none

    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = 25'd0;
    ioctl_dout     = 8'd0;
    dn_ready       = 1'b1;
    repeat (3) step();

    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_loaded",     32'(loaded),     32'd0);
    chk("rst_dn_wr",      32'(dn_wr),      32'd0);
    chk("rst_wait",       32'(ioctl_wait), 32'd0);
    chk("rst_byte_count", 32'(byte_count), 32'd0);
    chk("rst_overflow",   32'(overflow),   32'd0);
    chk("rst_dn_addr",    32'(dn_addr),    32'd0);
    chk("rst_dn_data",    32'(dn_data),    32'd0);
    reset = 1'b0;
    step();

    // Four-byte load with latency checks.
    ioctl_download = 1'b1;
    step();
    for (int i = 0; i < 4; i++) wr_byte(25'(i), t1_data[i], 1'b1);
    ioctl_download = 1'b0;
    // 1 cycle to DRAIN, 1 to HOLD, 16 in HOLD -> RUN visible 18 steps after the fall.
    wait_loaded(n);
    chk("t1_hold_len",   32'(n),          32'd18);
    chk("t1_core_reset", 32'(core_reset), 32'd0);
    chk("t1_loaded",     32'(loaded),     32'd1);
    chk("t1_byte_count", 32'(byte_count), 32'd4);
    chk("t1_overflow",   32'(overflow),   32'd0);

    // Foreign index download while running must be invisible.
    ioctl_download = 1'b1;
    ioctl_index    = 8'd1;
    for (int i = 0; i < 3; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = 8'(8'hE0 + i);
      step();
    end
    ioctl_wr = 1'b0;
    step();
    chk("idx1_core_reset", 32'(core_reset), 32'd0);
    chk("idx1_loaded",     32'(loaded),     32'd1);
    chk("idx1_byte_count", 32'(byte_count), 32'd4);
    ioctl_download = 1'b0;
    step();
    ioctl_index = 8'd0;

    // New download from RUN re-asserts the core reset on the next cycle.
    ioctl_download = 1'b1;
    step();
    chk("rerun_core_reset", 32'(core_reset), 32'd1);
    chk("rerun_loaded",     32'(loaded),     32'd0);
    chk("rerun_byte_count", 32'(byte_count), 32'd0);

    // Back-pressure: target stalls for 10 cycles across a 3-byte burst.
    dn_ready = 1'b0;
    wr_byte(25'h0000100, 8'hC3, 1'b0);
    chk("bp_wait_after_1", 32'(ioctl_wait), 32'd0);
    wr_byte(25'h0000101, 8'h3C, 1'b0);
    chk("bp_wait_after_2", 32'(ioctl_wait), 32'd1);
    repeat (8) step();
    chk("bp_wait_held", 32'(ioctl_wait), 32'd1);
    dn_ready = 1'b1;
    wr_byte(25'h0000102, 8'h96, 1'b0);
    repeat (3) step();
    chk("bp_overflow",   32'(overflow),   32'd0);
    chk("bp_byte_count", 32'(byte_count), 32'd3);

    // Out-of-range address is dropped and flagged.
    wr_byte(25'h0004000, 8'h77, 1'b0);
    step();
    chk("oor_overflow",   32'(overflow),   32'd1);
    chk("oor_byte_count", 32'(byte_count), 32'd3);
    ioctl_download = 1'b0;
    wait_loaded(n);
    chk("t4_loaded",     32'(loaded),     32'd1);
    chk("t4_byte_count", 32'(byte_count), 32'd3);
    chk("t4_overflow",   32'(overflow),   32'd1);

    // Zero-byte download: entry clears overflow, then hold returns to IDLE.
    ioctl_download = 1'b1;
    step();
    chk("zb_overflow_clr", 32'(overflow),   32'd0);
    chk("zb_core_reset",   32'(core_reset), 32'd1);
    ioctl_download = 1'b0;
    repeat (25) step();
    chk("zb_loaded",     32'(loaded),     32'd0);
    chk("zb_core_reset2", 32'(core_reset), 32'd1);
    chk("zb_byte_count", 32'(byte_count), 32'd0);

    // Reset mid-load with two bytes buffered.
    ioctl_download = 1'b1;
    step();
    dn_ready = 1'b0;
    wr_byte(25'h0000000, 8'h11, 1'b0);
    wr_byte(25'h0000001, 8'h22, 1'b0);
    chk("mr_wait_full", 32'(ioctl_wait), 32'd1);
    reset = 1'b1;
    sb.delete();
    step();
    reset = 1'b0;
    chk("mr_dn_wr",       32'(dn_wr),      32'd0);
    chk("mr_wait",        32'(ioctl_wait), 32'd0);
    chk("mr_byte_count",  32'(byte_count), 32'd0);
    chk("mr_core_reset",  32'(core_reset), 32'd1);
    chk("mr_loaded",      32'(loaded),     32'd0);
    chk("mr_dn_addr",     32'(dn_addr),    32'd0);
    dn_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i + 5);
      ioctl_dout = 8'h99;
      step();
    end
    ioctl_wr = 1'b0;
    repeat (3) step();
    chk("mr_no_reentry_count", 32'(byte_count), 32'd0);
    chk("mr_no_reentry_dn_wr", 32'(dn_wr),      32'd0);
    ioctl_download = 1'b0;
    repeat (2) step();

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
